ulpi_phy_tx_responder: RTL and testbench

- Synthesisable PHY-side responder for the ULPI link transmit path: the PHY end of the interface that `usb_ulpi_top` initiates on.
- Accepts link TX CMDs and throttles the link with NXT.
- Forwards transmitted USB packets (PID byte first) as an AXI4-Stream.
- Services ULPI register write/read commands against an external register file.
- Used in benches and loopback builds in place of the VPI host model, to capture exactly what the device core transmits.

---
 rtl/ulpi_phy_tx_responder_if.sv | 41 ++++
 rtl/ulpi_phy_tx_responder.sv | 172 +++++++++++++++++
 tb/tb_ulpi_phy_tx_responder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_phy_tx_responder_if.sv
// ULPI PHY-side transmit responder bus bundle.
//   ULPI link side : ulpi_dir_o, ulpi_nxt_o, ulpi_data_o (PHY driven), ulpi_stp_i, ulpi_data_i
//   Register file  : reg_addr_o, reg_wdata_o, reg_we_o, reg_rdata_i (combinational from address)
//   Packet stream  : m_tvalid_o, m_tready_i, m_tlast_o, m_tuser_o, m_tdata_o (AXI4-Stream)
// The master modport is the responder; the slave modport is its environment (link + sinks).
interface ulpi_phy_tx_responder_if #(
  parameter int unsigned REG_ABITS = 6
);
  logic                 ulpi_dir_o;
  logic                 ulpi_nxt_o;
  logic                 ulpi_stp_i;
  logic [7:0]           ulpi_data_i;
  logic [7:0]           ulpi_data_o;
  logic [REG_ABITS-1:0] reg_addr_o;
  logic [7:0]           reg_wdata_o;
  logic                 reg_we_o;
  logic [7:0]           reg_rdata_i;
  logic                 m_tvalid_o;
  logic                 m_tready_i;
  logic                 m_tlast_o;
  logic                 m_tuser_o;
  logic [7:0]           m_tdata_o;

  modport master (
    output ulpi_dir_o, ulpi_nxt_o, ulpi_data_o,
    input  ulpi_stp_i, ulpi_data_i,
    output reg_addr_o, reg_wdata_o, reg_we_o,
    input  reg_rdata_i,
    output m_tvalid_o, m_tlast_o, m_tuser_o, m_tdata_o,
    input  m_tready_i
  );

  modport slave (
    input  ulpi_dir_o, ulpi_nxt_o, ulpi_data_o,
    output ulpi_stp_i, ulpi_data_i,
    input  reg_addr_o, reg_wdata_o, reg_we_o,
    output reg_rdata_i,
    input  m_tvalid_o, m_tlast_o, m_tuser_o, m_tdata_o,
    output m_tready_i
  );
endinterface

// File: rtl/ulpi_phy_tx_responder.sv
// PHY end of the ULPI transmit path. Accepts link TX CMDs, throttles the link with NXT,
// forwards transmitted packets (PID byte first) as an AXI4-Stream and services immediate
// register write/read commands against an external register file.
// Ports:
//   clock  ULPI 60 MHz clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    ulpi_phy_tx_responder_if.master (ULPI link, register file, packet stream)
module ulpi_phy_tx_responder #(
  parameter int unsigned FBITS     = 4,
  parameter int unsigned REG_ABITS = 6
) (
  input logic                     clock,
  input logic                     rst_n,
  ulpi_phy_tx_responder_if.master bus
);
  localparam int unsigned Depth = 1 << FBITS;
  localparam int unsigned CntW  = FBITS + 1;

  typedef enum logic [2:0] {
    StIdle, StCmdAck, StTxData, StWrData, StWrStb, StRdTurn1, StRdData, StRdTurn2
  } state_e;

  state_e               state_q, state_d;
  logic                 nxt_q, nxt_d;
  logic                 dir_q, dir_d;
  logic [7:0]           dout_q, dout_d;
  logic [REG_ABITS-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [7:0]           stage_q, stage_d;

  // Packet FIFO entries are {tuser, tlast, tdata}.
  logic [9:0]       mem_q [Depth];
  logic [FBITS-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d, free_space;
  logic             push, pop, tx_room;
  logic [9:0]       push_word;
  logic             out_valid_q;
  logic [9:0]       out_q;

  // NXT is registered, so one more byte can land after it is decided, plus the staged byte
  // that stp flushes: three free slots keep the FIFO from ever overflowing.
  assign free_space = CntW'(Depth) - count_q;
  assign tx_room    = free_space >= CntW'(3);

  // Output register in front of the FIFO keeps the stream beat stable under backpressure.
  assign pop     = (count_q != '0) && (!out_valid_q || bus.m_tready_i);
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d   = state_q;
    nxt_d     = 1'b0;
    dir_d     = 1'b0;
    dout_d    = 8'h00;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    stage_d   = stage_q;
    push      = 1'b0;
    push_word = {2'b00, stage_q};
    unique case (state_q)
      StIdle: begin
        if (bus.ulpi_data_i != 8'h00 && !dir_q) begin
          state_d = StCmdAck;
          nxt_d   = 1'b1;
        end
      end
      StCmdAck: begin
        unique case (bus.ulpi_data_i[7:6])
          2'b00: state_d = StIdle;
          2'b01: begin
            stage_d = {~bus.ulpi_data_i[3:0], bus.ulpi_data_i[3:0]};
            nxt_d   = tx_room;
            state_d = StTxData;
          end
          2'b10: begin
            addr_d  = REG_ABITS'(bus.ulpi_data_i[5:0]);
            nxt_d   = 1'b1;
            state_d = StWrData;
          end
          2'b11: begin
            addr_d  = REG_ABITS'(bus.ulpi_data_i[5:0]);
            dir_d   = 1'b1;
            state_d = StRdTurn1;
          end
        endcase
      end
      StTxData: begin
        if (bus.ulpi_stp_i) begin
          // Final flush of the staged byte; link data FF on stp marks an abort.
          push      = 1'b1;
          push_word = {bus.ulpi_data_i == 8'hFF, 1'b1, stage_q};
          state_d   = StIdle;
        end else begin
          nxt_d = tx_room;
          if (nxt_q) begin
            push    = 1'b1;
            stage_d = bus.ulpi_data_i;
          end
        end
      end
      StWrData: begin
        wdata_d = bus.ulpi_data_i;
        we_d    = 1'b1;
        state_d = StWrStb;
      end
      StWrStb: state_d = StIdle;
      StRdTurn1: begin
        dir_d   = 1'b1;
        dout_d  = bus.reg_rdata_i;
        state_d = StRdData;
      end
      StRdData:  state_d = StRdTurn2;
      StRdTurn2: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      nxt_q       <= 1'b0;
      dir_q       <= 1'b0;
      dout_q      <= 8'h00;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      stage_q     <= 8'h00;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      stage_q <= stage_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + FBITS'(1);
      end
      if (pop) begin
        rptr_q      <= rptr_q + FBITS'(1);
        out_q       <= mem_q[rptr_q];
        out_valid_q <= 1'b1;
      end else if (bus.m_tready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  assign bus.ulpi_dir_o  = dir_q;
  assign bus.ulpi_nxt_o  = nxt_q;
  assign bus.ulpi_data_o = dout_q;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_we_o    = we_q;
  assign bus.m_tvalid_o  = out_valid_q;
  assign bus.m_tdata_o   = out_q[7:0];
  assign bus.m_tlast_o   = out_q[8];
  assign bus.m_tuser_o   = out_q[9];
endmodule

// File: tb/tb_ulpi_phy_tx_responder.sv
// Self-checking bench for ulpi_phy_tx_responder: a ULPI link driver, an external register
// file, a packet-level expected-beat queue and one stream compare process.
module tb_ulpi_phy_tx_responder;
  localparam int unsigned FBITS     = 4;
  localparam int unsigned REG_ABITS = 6;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  ulpi_phy_tx_responder_if #(.REG_ABITS(REG_ABITS)) bus ();

  ulpi_phy_tx_responder #(.FBITS(FBITS), .REG_ABITS(REG_ABITS)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // External register file written by the DUT strobe; exp_regs holds what the bench intended.
  logic [7:0] ext_regs [64];
  logic [7:0] exp_regs [64];
  logic [5:0] written[$];
  assign bus.reg_rdata_i = ext_regs[bus.reg_addr_o];
  always @(posedge clock) if (rst_n && bus.reg_we_o) ext_regs[bus.reg_addr_o] <= bus.reg_wdata_o;

  int we_pulses = 0;
  int nxt_hi = 0;
  always @(negedge clock) begin
    if (rst_n && bus.reg_we_o) we_pulses++;
    if (rst_n && bus.ulpi_nxt_o && !bus.ulpi_stp_i) nxt_hi++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for nxt (t=%0t)", name, $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  endtask

  // Stream model: expected beats {tuser, tlast, tdata} in delivery order.
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  bit         lat_arm = 1'b0;
  int         first_valid_cyc = -1;

  always @(negedge clock) begin
    logic [9:0] beat;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      beat = {bus.m_tuser_o, bus.m_tlast_o, bus.m_tdata_o};
      if (lat_arm && bus.m_tvalid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        chk("axis_hold_valid", bus.m_tvalid_o, 1'b1);
        chk("axis_hold_beat", beat, prev_beat);
      end
      if (bus.m_tvalid_o && bus.m_tready_i) begin
        got_q.push_back(beat);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL axis_unexpected_beat got=%0h expected=none", beat);
        end else begin
          chk("axis_beat", beat, exp_q.pop_front());
        end
      end
      prev_stall = bus.m_tvalid_o && !bus.m_tready_i;
      prev_beat  = beat;
    end
  end

  // 0: ready held high, 1: ready held low, 2: random ready
  int rmode = 0;
  initial begin
    bus.m_tready_i = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0:       bus.m_tready_i = 1'b1;
        1:       bus.m_tready_i = 1'b0;
        default: bus.m_tready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Drive one link byte and hold it until the PHY accepts it (nxt high in that cycle).
  // Entered and left just after a rising edge; acc_cyc is the cycle of acceptance.
  task automatic link_byte(input logic [7:0] b, output int acc_cyc);
    bit acc = 1'b0;
    acc_cyc = -1;
    bus.ulpi_data_i = b;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clock);
      acc = bus.ulpi_nxt_o;
      if (acc) acc_cyc = cyc;
      @(posedge clock);
      #1;
    end
    if (!acc) timeout("link_byte");
  endtask

  logic [7:0] pkt[$];
  int tx_acc = 0;

  // Transmit PID + pkt bytes; the expected beats are computed from the packet itself.
  task automatic send_tx(input logic [3:0] pid, input bit abort, output int lat_cyc);
    int c;
    int n = pkt.size();
    exp_q.push_back({(n == 0) && abort, n == 0, ~pid, pid});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1) && abort, i == n - 1, pkt[i]});
    lat_cyc = -1;
    link_byte({4'b0100, pid}, c);
    for (int i = 0; i < n; i++) begin
      link_byte(pkt[i], c);
      if (i == 0) lat_cyc = c;
      tx_acc++;
    end
    bus.ulpi_stp_i  = 1'b1;
    bus.ulpi_data_i = abort ? 8'hFF : 8'h00;
    @(posedge clock);
    #1;
    bus.ulpi_stp_i  = 1'b0;
    bus.ulpi_data_i = 8'h00;
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
    int c;
    int p0 = we_pulses;
    link_byte({2'b10, a}, c);
    link_byte(d, c);
    bus.ulpi_stp_i  = 1'b1;
    bus.ulpi_data_i = 8'h00;
    @(negedge clock);
    chk("reg_we_on_stp", bus.reg_we_o, 1'b1);
    chk("reg_addr_wr", bus.reg_addr_o, a);
    chk("reg_wdata", bus.reg_wdata_o, d);
    @(posedge clock);
    #1;
    bus.ulpi_stp_i = 1'b0;
    @(negedge clock);
    chk("reg_we_drop", bus.reg_we_o, 1'b0);
    chk("reg_we_pulses", we_pulses, p0 + 1);
    @(posedge clock);
    #1;
    exp_regs[a] = d;
    written.push_back(a);
  endtask

  task automatic reg_read(input logic [5:0] a);
    int c;
    link_byte({2'b11, a}, c);
    bus.ulpi_data_i = 8'h00;
    @(negedge clock);
    chk("rd_turn1_dir", bus.ulpi_dir_o, 1'b1);
    chk("rd_turn1_data", bus.ulpi_data_o, 8'h00);
    @(negedge clock);
    chk("rd_data_dir", bus.ulpi_dir_o, 1'b1);
    chk("rd_data", bus.ulpi_data_o, exp_regs[a]);
    chk("rd_addr", bus.reg_addr_o, a);
    @(negedge clock);
    chk("rd_turn2_dir", bus.ulpi_dir_o, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.ulpi_stp_i  = 1'b0;
    bus.ulpi_data_i = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs();
    @(negedge clock);
    chk("rst_nxt", bus.ulpi_nxt_o, 1'b0);
    chk("rst_dir", bus.ulpi_dir_o, 1'b0);
    chk("rst_data_o", bus.ulpi_data_o, 8'h00);
    chk("rst_we", bus.reg_we_o, 1'b0);
    chk("rst_addr", bus.reg_addr_o, 6'h00);
    chk("rst_wdata", bus.reg_wdata_o, 8'h00);
    chk("rst_tvalid", bus.m_tvalid_o, 1'b0);
    chk("rst_tbeat", {bus.m_tuser_o, bus.m_tlast_o, bus.m_tdata_o}, 10'h000);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    rmode = 0;
    repeat (40) @(posedge clock);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c, n0, op;
    bus.ulpi_stp_i  = 1'b0;
    bus.ulpi_data_i = 8'h00;
    do_reset();
    check_idle_outputs();

    // DATA0: C3, A5, 5A; latency and nxt usage pinned by hand.
    got_q.delete();
    pkt = '{8'hA5, 8'h5A};
    n0 = nxt_hi;
    lat_arm = 1'b1;
    first_valid_cyc = -1;
    send_tx(4'h3, 1'b0, lat);
    drain();
    lat_arm = 1'b0;
    chk("data0_latency", first_valid_cyc - lat, 2);
    chk("data0_nxt_cycles", nxt_hi - n0, 3);
    chk("data0_beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("data0_b0", got_q[0], 10'h0C3);
      chk("data0_b1", got_q[1], 10'h0A5);
      chk("data0_b2", got_q[2], 10'h15A);
    end

    // Handshake ACK: single PID beat with tlast.
    got_q.delete();
    pkt.delete();
    send_tx(4'h2, 1'b0, lat);
    drain();
    chk("ack_beats", got_q.size(), 1);
    if (got_q.size() == 1) chk("ack_b0", got_q[0], 10'h1D2);

    // Backpressure: 20-byte packet into a 16-deep FIFO with ready low.
    got_q.delete();
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom_range(0, 255)));
    rmode = 1;
    tx_acc = 0;
    fork
      send_tx(4'hB, 1'b0, lat);
      begin
        repeat (80) @(posedge clock);
        @(negedge clock);
        chk("bp_nxt_low", bus.ulpi_nxt_o, 1'b0);
        chk("bp_tvalid", bus.m_tvalid_o, 1'b1);
        chk("bp_accepted_le16", tx_acc <= 16, 1'b1);
        chk("bp_accepted_ge8", tx_acc >= 8, 1'b1);
        rmode = 0;
      end
    join
    drain();
    chk("bp_beats", got_q.size(), 21);

    // Abort after 3 bytes.
    got_q.delete();
    pkt = '{8'h11, 8'h22, 8'h33};
    send_tx(4'h1, 1'b1, lat);
    drain();
    chk("abort_beats", got_q.size(), 4);
    if (got_q.size() == 4) chk("abort_last", got_q[3], 10'h333);

    // Register write then read-back, including the extended address.
    reg_write(6'h04, 8'h3C);
    reg_write(6'h07, 8'h99);
    reg_write(6'h2F, 8'h5E);
    reg_read(6'h07);
    reg_read(6'h2F);

    // Reset in the middle of a packet.
    rmode = 1;
    link_byte(8'h45, c);
    link_byte(8'hDE, c);
    link_byte(8'hAD, c);
    do_reset();
    got_q.delete();
    rmode = 0;
    check_idle_outputs();
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_tvalid", bus.m_tvalid_o, 1'b0);
    end
    @(posedge clock);
    #1;
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_tx(4'h3, 1'b0, lat);
    drain();
    chk("post_rst_beats", got_q.size(), 5);

    // Random mix of packets and register traffic.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        pkt.delete();
        for (int i = 0; i < int'($urandom_range(0, 24)); i++)
          pkt.push_back(8'($urandom_range(0, 255)));
        rmode = int'($urandom_range(0, 1)) * 2;
        send_tx(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, lat);
      end else if (op <= 7 || written.size() == 0) begin
        reg_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      end else begin
        reg_read(written[$urandom_range(0, written.size() - 1)]);
      end
    end
    drain();
    chk("model_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
